// File: rtl/fetch_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the fetch front end.
package fetch_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [PC_W-1:0] pc,
                                                      input logic [INSTR_W-1:0] instr);
        entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        return entry_t'(raw);
    endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction memory request/response, redirect and decode handshake.
interface fetch_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc,instr} FIFO; clear wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [ENTRY_W-1:0]       din_i,
    input  logic                     pop_i,
    output logic [ENTRY_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, keeps one request in flight to imem and buffers
// returned words for decode; redirects flush the buffer and drop stale responses.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_e           state_q;
    logic [PC_W-1:0]  fetch_pc_q;
    logic [PC_W-1:0]  req_pc_q;
    logic             drop_q;
    logic             outstanding_q;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    entry_t             head;
    logic               credit_ok;
    logic               req_fire;
    logic               rsp_fire;
    logic               push;
    logic               pop;

    // Credit counts the in-flight word so a returning response always has a slot.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(FIFO_DEPTH);

    // Redirect suppresses issue combinationally so memory never accepts a stale-path fetch.
    assign bus.imem_req_valid = !reset && !bus.redirect && (state_q == ST_ISSUE) && credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = (state_q == ST_WAIT) && outstanding_q && bus.imem_rsp_valid;
    assign push     = rsp_fire && !drop_q && !fifo_full;
    assign pop      = bus.if_valid && bus.if_ready;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.redirect),
        .push_i  (push),
        .din_i   (pack_entry(req_pc_q, bus.imem_rsp_data)),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head         = unpack_entry(fifo_head);
    assign bus.if_valid = !fifo_empty;
    assign bus.if_instr = fifo_empty ? '0 : head.instr;
    assign bus.if_pc    = fifo_empty ? '0 : head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ISSUE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            drop_q        <= 1'b0;
            outstanding_q <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc_q <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            // A response landing this cycle is consumed (discarded) now; otherwise wait it out.
            if (outstanding_q && !bus.imem_rsp_valid) begin
                drop_q  <= 1'b1;
                state_q <= ST_WAIT;
            end else begin
                drop_q        <= 1'b0;
                outstanding_q <= 1'b0;
                state_q       <= ST_ISSUE;
            end
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (req_fire) begin
                        outstanding_q <= 1'b1;
                        req_pc_q      <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_q + PC_W'(4);
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_fire) begin
                        outstanding_q <= 1'b0;
                        drop_q        <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a cycle-level imem model.
module tb_instruction_fetch_unit;
    logic clk;
    logic reset;
    fetch_if bus();

    instruction_fetch_unit #(.RESET_PC(64'h1000), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;

    // imem model state
    logic        mem_busy;
    int          mem_cnt;
    logic [63:0] mem_addr;
    int          lat;
    logic        force_rsp;

    logic [63:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [63:0] req_log[$];
    int          vld_cycles;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1300_0013 ^ {a[23:0], 8'h5A};
    endfunction

    // One clock: drive response, sample handshakes, cross posedge, update model, land on negedge.
    task automatic tick();
        logic        rsp_now;
        logic        req_now;
        logic [63:0] addr_now;
        bus.imem_rsp_valid = force_rsp || (mem_busy && mem_cnt == 0);
        bus.imem_rsp_data  = force_rsp ? 32'hDEAD_BEEF : mem_word(mem_addr);
        #1;
        rsp_now  = bus.imem_rsp_valid;
        req_now  = bus.imem_req_valid && bus.imem_req_ready;
        addr_now = bus.imem_req_addr;
        if (bus.imem_req_valid) vld_cycles++;
        if (bus.if_valid && bus.if_ready) begin
            pop_pc.push_back(bus.if_pc);
            pop_ins.push_back(bus.if_instr);
        end
        if (req_now) req_log.push_back(addr_now);
        @(posedge clk);
        if (reset) begin
            mem_busy = 1'b0;
        end else begin
            if (rsp_now && !force_rsp) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (req_now) begin
                mem_busy = 1'b1;
                mem_addr = addr_now;
                mem_cnt  = lat - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_ins.delete();
        req_log.delete();
        vld_cycles = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        force_rsp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0b want 0", bus.imem_req_valid); else n_pass++;
        n_chk++; if (bus.imem_req_addr !== 64'h1000) $display("FAIL reset_req_addr got %h want 1000", bus.imem_req_addr); else n_pass++;
        n_chk++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid got %0b want 0", bus.if_valid); else n_pass++;
        n_chk++; if (bus.if_instr !== 32'h0) $display("FAIL reset_if_instr got %h want 0", bus.if_instr); else n_pass++;
        n_chk++; if (bus.if_pc !== 64'h0) $display("FAIL reset_if_pc got %h want 0", bus.if_pc); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL post_reset_req_valid got %0b want 1", bus.imem_req_valid); else n_pass++;
        clear_logs();
    endtask

    task automatic test_stream();
        int bad;
        do_reset();
        lat = 1;
        bus.if_ready = 1'b1;
        repeat (14) tick();
        n_chk++; if (pop_pc.size() < 3) $display("FAIL stream_count got %0d want >=3", pop_pc.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [63:0] got;
            got = (i < pop_pc.size()) ? pop_pc[i] : '1;
            n_chk++; if (got !== 64'h1000 + 64'(4*i)) $display("FAIL stream_pc%0d got %h want %h", i, got, 64'h1000 + 64'(4*i)); else n_pass++;
        end
        n_chk++; if (pop_ins.size() == 0 || pop_ins[0] !== mem_word(64'h1000)) $display("FAIL stream_instr0 got %h want %h", (pop_ins.size() > 0) ? pop_ins[0] : 32'h0, mem_word(64'h1000)); else n_pass++;
        bad = 0;
        for (int i = 0; i < pop_pc.size(); i++) if (pop_pc[i] !== 64'h1000 + 64'(4*i)) bad++;
        n_chk++; if (bad != 0) $display("FAIL stream_order got %0d bad entries want 0", bad); else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        lat = 1;
        bus.if_ready = 1'b0;
        repeat (8) tick();
        vld_cycles = 0;
        repeat (12) tick();
        #1;
        n_chk++; if (vld_cycles != 0) $display("FAIL stall_req_cycles got %0d want 0", vld_cycles); else n_pass++;
        n_chk++; if (pop_pc.size() != 0) $display("FAIL stall_pops got %0d want 0", pop_pc.size()); else n_pass++;
        n_chk++; if (bus.if_valid !== 1'b1) $display("FAIL stall_if_valid got %0b want 1", bus.if_valid); else n_pass++;
        n_chk++; if (bus.if_pc !== 64'h1000) $display("FAIL stall_head_pc got %h want 1000", bus.if_pc); else n_pass++;
        n_chk++; if (req_log.size() != 4) $display("FAIL stall_req_total got %0d want 4", req_log.size()); else n_pass++;
        bus.if_ready = 1'b1;
        repeat (16) tick();
        bad = (pop_pc.size() < 5) ? 99 : 0;
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) if (pop_pc[i] !== 64'h1000 + 64'(4*i)) bad++;
        n_chk++; if (bad != 0) $display("FAIL stall_drain got %0d bad want 0 (pops=%0d)", bad, pop_pc.size()); else n_pass++;
    endtask

    task automatic test_redirect_outstanding();
        logic found;
        int   bad;
        do_reset();
        lat = 3;
        bus.if_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (req_log.size() > 0 && req_log[req_log.size()-1] == 64'h1010) found = 1'b1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL redir_setup got %0b want 1 (no 1010 request)", found); else n_pass++;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h2002;
        tick();
        bus.redirect = 1'b0;
        clear_logs();
        repeat (24) tick();
        n_chk++; if (req_log.size() == 0 || req_log[0] !== 64'h2000) $display("FAIL redir_first_req got %h want 2000", (req_log.size() > 0) ? req_log[0] : 64'h0); else n_pass++;
        n_chk++; if (pop_pc.size() == 0 || pop_pc[0] !== 64'h2000) $display("FAIL redir_first_pc got %h want 2000", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0); else n_pass++;
        n_chk++; if (pop_ins.size() == 0 || pop_ins[0] !== mem_word(64'h2000)) $display("FAIL redir_first_instr got %h want %h", (pop_ins.size() > 0) ? pop_ins[0] : 32'h0, mem_word(64'h2000)); else n_pass++;
        bad = 0;
        for (int i = 0; i < pop_pc.size(); i++) if (pop_pc[i] !== 64'h2000 + 64'(4*i)) bad++;
        n_chk++; if (bad != 0) $display("FAIL redir_stale got %0d bad entries want 0", bad); else n_pass++;
    endtask

    task automatic test_redirect_rsp_pop();
        do_reset();
        lat = 1;
        bus.if_ready = 1'b0;
        repeat (5) tick();
        bus.if_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h3000;
        tick();
        bus.redirect = 1'b0;
        #1;
        n_chk++; if (pop_pc.size() != 1) $display("FAIL rrp_pop_count got %0d want 1", pop_pc.size()); else n_pass++;
        n_chk++; if (pop_pc.size() == 0 || pop_pc[0] !== 64'h1000) $display("FAIL rrp_pop_pc got %h want 1000", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0); else n_pass++;
        n_chk++; if (bus.if_valid !== 1'b0) $display("FAIL rrp_empty got %0b want 0", bus.if_valid); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rrp_req_valid got %0b want 1", bus.imem_req_valid); else n_pass++;
        n_chk++; if (bus.imem_req_addr !== 64'h3000) $display("FAIL rrp_req_addr got %h want 3000", bus.imem_req_addr); else n_pass++;
        clear_logs();
        repeat (10) tick();
        n_chk++; if (pop_pc.size() == 0 || pop_pc[0] !== 64'h3000) $display("FAIL rrp_next_pc got %h want 3000", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0); else n_pass++;
    endtask

    task automatic test_double_redirect();
        int bad_req;
        int bad_pop;
        do_reset();
        lat = 5;
        bus.if_ready = 1'b1;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h4000;
        tick();
        bus.redirect = 1'b0;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h5001;
        tick();
        bus.redirect = 1'b0;
        pop_pc.delete();
        pop_ins.delete();
        repeat (25) tick();
        n_chk++; if (req_log.size() < 2 || req_log[1] !== 64'h5000) $display("FAIL dbl_second_req got %h want 5000", (req_log.size() > 1) ? req_log[1] : 64'h0); else n_pass++;
        bad_req = 0;
        for (int i = 0; i < req_log.size(); i++) if (req_log[i][63:12] == 52'h4) bad_req++;
        n_chk++; if (bad_req != 0) $display("FAIL dbl_first_target got %0d fetches want 0", bad_req); else n_pass++;
        n_chk++; if (pop_pc.size() == 0 || pop_pc[0] !== 64'h5000) $display("FAIL dbl_first_pc got %h want 5000", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0); else n_pass++;
        bad_pop = 0;
        for (int i = 0; i < pop_pc.size(); i++) if (pop_pc[i] !== 64'h5000 + 64'(4*i)) bad_pop++;
        n_chk++; if (bad_pop != 0) $display("FAIL dbl_stale_pops got %0d want 0", bad_pop); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        lat = 4;
        bus.if_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.imem_req_ready = 1'b0;
        force_rsp = 1'b1;
        clear_logs();
        tick();
        force_rsp = 1'b0;
        #1;
        n_chk++; if (bus.if_valid !== 1'b0) $display("FAIL rw_if_valid got %0b want 0", bus.if_valid); else n_pass++;
        n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rw_req_valid got %0b want 1", bus.imem_req_valid); else n_pass++;
        n_chk++; if (bus.imem_req_addr !== 64'h1000) $display("FAIL rw_req_addr got %h want 1000", bus.imem_req_addr); else n_pass++;
        bus.imem_req_ready = 1'b1;
        lat = 1;
        repeat (6) tick();
        n_chk++; if (pop_pc.size() == 0 || pop_pc[0] !== 64'h1000) $display("FAIL rw_first_pc got %h want 1000", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0); else n_pass++;
        n_chk++; if (pop_ins.size() == 0 || pop_ins[0] !== mem_word(64'h1000)) $display("FAIL rw_first_instr got %h want %h", (pop_ins.size() > 0) ? pop_ins[0] : 32'h0, mem_word(64'h1000)); else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        mem_busy = 1'b0;
        mem_cnt = 0;
        mem_addr = '0;
        lat = 1;
        force_rsp = 1'b0;
        vld_cycles = 0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b1;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_rsp_pop();
        test_double_redirect();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
